// File: rtl/ptw_mem_responder_pkg.sv
// Shared types for the PTW memory responder: dcache request/response
// structs as driven by the page table walker, plus the responder FSM states.
package ptw_mem_responder_pkg;

    typedef struct packed {
        logic [11:0] address_index;
        logic [43:0] address_tag;
        logic [63:0] data_wdata;
        logic        data_req;
        logic        data_we;
        logic [7:0]  data_be;
        logic [1:0]  data_size;
        logic        kill_req;
        logic        tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;

    typedef enum logic [1:0] {
        IDLE,
        TAG,
        WAIT,
        RESP
    } ptw_mem_state_e;

endpackage

// File: rtl/ptw_mem_responder_if.sv
// dcache request port bundle: the requester (PTW) owns req_port_i, the
// responder owns req_port_o.
interface ptw_mem_responder_if import ptw_mem_responder_pkg::*; ;

    dcache_req_i_t req_port_i;
    dcache_req_o_t req_port_o;

    modport master (output req_port_i, input  req_port_o);
    modport slave  (input  req_port_i, output req_port_o);

endinterface

// File: rtl/ptw_mem_sram.sv
// 64-bit word scratchpad: combinational read, byte-enabled synchronous write,
// plus a full-word backdoor port that wins over a same-word port write.
module ptw_mem_sram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [7:0]               be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [63:0]              wdata_i,
    output logic [63:0]              rdata_o,
    input  logic                     init_we_i,
    input  logic [$clog2(DEPTH)-1:0] init_addr_i,
    input  logic [63:0]              init_data_i
);

    logic [63:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Port write masked per byte; suppressed when the backdoor hits the same word.
    always_ff @(posedge clk_i) begin
        if (we_i && !(init_we_i && (init_addr_i == addr_i))) begin
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (init_we_i) mem_q[init_addr_i] <= init_data_i;
    end

endmodule

// File: rtl/ptw_mem_responder.sv
// Memory-side responder for the PTW dcache port: index phase with grant,
// tag phase, then a read response LATENCY cycles after the tag.
// Optional macro PTW_MEM_RESPONDER_STALL_EN: LFSR-driven random grant stalls.
module ptw_mem_responder import ptw_mem_responder_pkg::*; #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [55:0] BASE_ADDR = 56'h0008_0000,
    parameter int unsigned LATENCY   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ptw_mem_responder_if.slave       req_port,
    input  logic                     init_we_i,
    input  logic [$clog2(DEPTH)-1:0] init_addr_i,
    input  logic [63:0]              init_data_i,
    output logic                     busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    dcache_req_i_t  req;
    ptw_mem_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [11:0]    index_q, index_d;
    logic           we_q, we_d;
    logic [7:0]     be_q, be_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [63:0]    rdata_q, rdata_d;
    logic [55:0]    paddr;
    logic           in_range, tag_hit, sram_we, gnt, rvalid, gnt_ok;
    logic [63:0]    sram_rdata;
    logic           unused_ok;

    assign req       = req_port.req_port_i;
    assign paddr     = {req.address_tag, index_q};
    // BASE_ADDR is DEPTH*8 aligned, so the range check is an upper-bit match.
    assign in_range  = (paddr[55:AW+3] == BASE_ADDR[55:AW+3]);
    assign tag_hit   = (state_q == TAG) && req.tag_valid && !req.kill_req;
    assign sram_we   = tag_hit && we_q && in_range;
    assign unused_ok = ^{req.data_size, paddr[2:0]};

`ifdef PTW_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q;
    // Fibonacci LFSR, taps 16,14,13,11; bit 0 low lets a grant through.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign gnt_ok = ~lfsr_q[0];
`else
    assign gnt_ok = 1'b1;
`endif

    ptw_mem_sram #(.DEPTH(DEPTH)) i_sram (
        .clk_i       (clk_i),
        .we_i        (sram_we),
        .be_i        (be_q),
        .addr_i      (paddr[AW+2:3]),
        .wdata_i     (wdata_q),
        .rdata_o     (sram_rdata),
        .init_we_i   (init_we_i),
        .init_addr_i (init_addr_i),
        .init_data_i (init_data_i)
    );

    // State and index-phase capture registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state, grant and response strobe; kill beats tag_valid in TAG.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt = req.data_req & gnt_ok;
                if (gnt) begin
                    index_d = req.address_index;
                    we_d    = req.data_we;
                    be_d    = req.data_be;
                    wdata_d = req.data_wdata;
                    state_d = TAG;
                end
            end
            TAG: begin
                if (req.kill_req) begin
                    state_d = IDLE;
                end else if (req.tag_valid) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = in_range ? sram_rdata : 64'h0;
                        if (LATENCY == 1) begin
                            state_d = RESP;
                        end else begin
                            cnt_d   = CW'(LATENCY - 1);
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (req.kill_req) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = RESP;
                end
            end
            RESP: begin
                rvalid  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_port.req_port_o = '{data_gnt: gnt, data_rvalid: rvalid, data_rdata: rdata_q};
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed bench for ptw_mem_responder (DEPTH=1024, BASE=0x80000, LATENCY=2).
module tb_ptw_mem_responder;
    import ptw_mem_responder_pkg::*;

    localparam logic [55:0] BASE = 56'h0008_0000;
    localparam int          LAT  = 2;
    localparam logic [55:0] OOR  = 56'h0008_2000;  // BASE + DEPTH*8

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        init_we_i;
    logic [9:0]  init_addr_i;
    logic [63:0] init_data_i;
    logic        busy_o;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stray = 0;

    always #5 clk_i = ~clk_i;

    ptw_mem_responder_if bus ();

    ptw_mem_responder #(.DEPTH(1024), .BASE_ADDR(BASE), .LATENCY(LAT), .LFSR_SEED(16'hACE1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_port    (bus),
        .init_we_i   (init_we_i),
        .init_addr_i (init_addr_i),
        .init_data_i (init_data_i),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] wa(input int w);
        return BASE + 56'(w * 8);
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bd_write(input logic [9:0] a, input logic [63:0] d);
        init_we_i = 1'b1; init_addr_i = a; init_data_i = d;
        cyc();
        init_we_i = 1'b0;
    endtask

    // Hold data_req until granted (bounded), then move into the tag-phase cycle.
    task automatic issue(input logic [55:0] pa, input logic we, input logic [7:0] be, input logic [63:0] wd);
        int w = 0;
        logic g = 1'b0;
        bus.req_port_i.address_index = pa[11:0];
        bus.req_port_i.data_we       = we;
        bus.req_port_i.data_be       = be;
        bus.req_port_i.data_wdata    = wd;
        bus.req_port_i.data_req      = 1'b1;
        while (!g && w < 50) begin
            @(negedge clk_i);
            g = bus.req_port_o.data_gnt;
            if (!g) begin
                w++;
                cyc();
            end
        end
        chk("gnt", 64'(g), 64'h1);
`ifndef PTW_MEM_RESPONDER_STALL_EN
        chk("gnt_first_cycle", 64'(w), 64'h0);
`endif
        cyc();
        bus.req_port_i.data_req = 1'b0;
    endtask

    task automatic tag_ph(input logic [55:0] pa, input int dly, input logic kill,
                          input logic bd, input logic [9:0] ba, input logic [63:0] bdat);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_i);
            chk("tag_wait_busy", 64'(busy_o), 64'h1);
            if (bus.req_port_o.data_rvalid) stray++;
            cyc();
        end
        bus.req_port_i.address_tag = pa[55:12];
        bus.req_port_i.tag_valid   = 1'b1;
        bus.req_port_i.kill_req    = kill;
        init_we_i = bd; init_addr_i = ba; init_data_i = bdat;
        @(negedge clk_i);
        if (bus.req_port_o.data_rvalid) stray++;
        cyc();
        bus.req_port_i.tag_valid = 1'b0;
        bus.req_port_i.kill_req  = 1'b0;
        init_we_i = 1'b0;
    endtask

    // Watch a fixed window after the tag cycle; first = cycles after tag of first rvalid.
    task automatic resp(output int first, output int n, output logic [63:0] d);
        first = -1; n = 0; d = '0;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk_i);
            if (bus.req_port_o.data_rvalid) begin
                n++;
                if (first < 0) begin
                    first = c;
                    d = bus.req_port_o.data_rdata;
                end
            end
            cyc();
        end
    endtask

    task automatic rd(input logic [55:0] pa, input int dly, input logic [63:0] exp, input string tg);
        int f, n;
        logic [63:0] d;
        issue(pa, 1'b0, 8'h00, 64'h0);
        tag_ph(pa, dly, 1'b0, 1'b0, 10'd0, 64'h0);
        resp(f, n, d);
        chk({tg, "_lat"}, 64'(f), 64'(LAT));
        chk({tg, "_nrv"}, 64'(n), 64'h1);
        chk({tg, "_data"}, d, exp);
    endtask

    task automatic wr(input logic [55:0] pa, input logic [7:0] be, input logic [63:0] wd,
                      input logic bd, input logic [9:0] ba, input logic [63:0] bdat, input string tg);
        int f, n;
        logic [63:0] d;
        issue(pa, 1'b1, be, wd);
        tag_ph(pa, 0, 1'b0, bd, ba, bdat);
        resp(f, n, d);
        chk({tg, "_nrv"}, 64'(n), 64'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, n;
        logic [63:0] d;
        logic g;
        bus.req_port_i = '0;
        init_we_i = 1'b0; init_addr_i = '0; init_data_i = '0;

        #12;
        chk("rst_gnt",    64'(bus.req_port_o.data_gnt),    64'h0);
        chk("rst_rvalid", 64'(bus.req_port_o.data_rvalid), 64'h0);
        chk("rst_rdata",  bus.req_port_o.data_rdata,       64'h0);
        chk("rst_busy",   64'(busy_o),                     64'h0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        bd_write(10'd5, 64'hDEAD_BEEF_0000_1111);
        bd_write(10'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        bd_write(10'd7, 64'hAAAA_AAAA_AAAA_AAAA);

        // Plain backdoor read: index 0x028, tag 0x80 -> word 5
        rd(wa(5), 0, 64'hDEAD_BEEF_0000_1111, "bd_read");

        // Byte-enable write then read back
        wr(wa(0), 8'h0F, 64'h1122_3344_5566_7788, 1'b0, 10'd0, 64'h0, "be_wr");
        rd(wa(0), 0, 64'hFFFF_FFFF_5566_7788, "be_read");

        // Kill in the tag cycle (write with tag_valid too): no write, no response
        issue(wa(5), 1'b1, 8'hFF, 64'h0);
        tag_ph(wa(5), 0, 1'b1, 1'b0, 10'd0, 64'h0);
        @(negedge clk_i);
        chk("kill_tag_busy",   64'(busy_o), 64'h0);
        chk("kill_tag_rvalid", 64'(bus.req_port_o.data_rvalid), 64'h0);
        cyc();
        resp(f, n, d);
        chk("kill_tag_nrv", 64'(n), 64'h0);
        rd(wa(5), 0, 64'hDEAD_BEEF_0000_1111, "after_kill_tag");

        // Kill in the first WAIT cycle
        issue(wa(0), 1'b0, 8'h00, 64'h0);
        tag_ph(wa(0), 0, 1'b0, 1'b0, 10'd0, 64'h0);
        bus.req_port_i.kill_req = 1'b1;
        @(negedge clk_i);
        chk("kill_wait_busy_pre", 64'(busy_o), 64'h1);
        cyc();
        bus.req_port_i.kill_req = 1'b0;
        @(negedge clk_i);
        chk("kill_wait_busy", 64'(busy_o), 64'h0);
        cyc();
        resp(f, n, d);
        chk("kill_wait_nrv", 64'(n), 64'h0);

        // Same-cycle backdoor write is not visible to the tag-cycle read
        issue(wa(7), 1'b0, 8'h00, 64'h0);
        tag_ph(wa(7), 0, 1'b0, 1'b1, 10'd7, 64'hBBBB_BBBB_BBBB_BBBB);
        resp(f, n, d);
        chk("bd_race_data", d, 64'hAAAA_AAAA_AAAA_AAAA);
        rd(wa(7), 0, 64'hBBBB_BBBB_BBBB_BBBB, "bd_race_after");

        // Backdoor wins same word; a different-word port write still commits
        wr(wa(8), 8'hFF, 64'h1111_1111_1111_1111, 1'b1, 10'd8, 64'h2222_2222_2222_2222, "bd_win_wr");
        rd(wa(8), 0, 64'h2222_2222_2222_2222, "bd_win");
        wr(wa(9), 8'hFF, 64'h3333_3333_3333_3333, 1'b1, 10'd10, 64'h4444_4444_4444_4444, "bd_other_wr");
        rd(wa(9), 0, 64'h3333_3333_3333_3333, "port_other");
        rd(wa(10), 0, 64'h4444_4444_4444_4444, "bd_other");

        // Out of range: read returns zero, write is dropped (would alias word 0)
        rd(OOR, 0, 64'h0, "oor_read");
        wr(OOR, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 10'd0, 64'h0, "oor_wr");
        rd(wa(0), 0, 64'hFFFF_FFFF_5566_7788, "oor_wr_unchanged");

        // Tag three cycles after grant
        rd(wa(5), 2, 64'hDEAD_BEEF_0000_1111, "dly_tag");

        // Second request held during TAG/WAIT/RESP is not granted
        issue(wa(5), 1'b0, 8'h00, 64'h0);
        bus.req_port_i.address_index = 12'h030;
        bus.req_port_i.data_req = 1'b1;
        @(negedge clk_i);
        chk("blk_tag_gnt", 64'(bus.req_port_o.data_gnt), 64'h0);
        cyc();
        bus.req_port_i.address_tag = wa(5)[55:12];
        bus.req_port_i.tag_valid = 1'b1;
        @(negedge clk_i);
        chk("blk_tagv_gnt", 64'(bus.req_port_o.data_gnt), 64'h0);
        cyc();
        bus.req_port_i.tag_valid = 1'b0;
        @(negedge clk_i);
        chk("blk_wait_gnt",    64'(bus.req_port_o.data_gnt), 64'h0);
        chk("blk_wait_rvalid", 64'(bus.req_port_o.data_rvalid), 64'h0);
        cyc();
        @(negedge clk_i);
        chk("blk_resp_rvalid", 64'(bus.req_port_o.data_rvalid), 64'h1);
        chk("blk_resp_data",   bus.req_port_o.data_rdata, 64'hDEAD_BEEF_0000_1111);
        chk("blk_resp_gnt",    64'(bus.req_port_o.data_gnt), 64'h0);
        cyc();
        @(negedge clk_i);
        g = bus.req_port_o.data_gnt;
`ifndef PTW_MEM_RESPONDER_STALL_EN
        chk("blk_idle_gnt", 64'(g), 64'h1);
`endif
        cyc();
        bus.req_port_i.data_req = 1'b0;
        if (g) begin
            bus.req_port_i.kill_req = 1'b1;
            @(negedge clk_i);
            cyc();
            bus.req_port_i.kill_req = 1'b0;
        end

        // Reset pulsed during WAIT: outputs clear at once, response is lost
        issue(wa(5), 1'b0, 8'h00, 64'h0);
        tag_ph(wa(5), 0, 1'b0, 1'b0, 10'd0, 64'h0);
        rst_ni = 1'b0;
        #1;
        chk("rstw_busy",   64'(busy_o), 64'h0);
        chk("rstw_rvalid", 64'(bus.req_port_o.data_rvalid), 64'h0);
        chk("rstw_rdata",  bus.req_port_o.data_rdata, 64'h0);
        chk("rstw_gnt",    64'(bus.req_port_o.data_gnt), 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        resp(f, n, d);
        chk("rstw_nrv", 64'(n), 64'h0);
        rd(wa(5), 0, 64'hDEAD_BEEF_0000_1111, "after_rst");

        chk("stray_rvalid", 64'(stray), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
